// File: rtl/count_monitor.sv
// Receiving-side monitor for a free-running counter: checks that each enabled
// sample advances by exactly +1 (mod 2^WIDTH), locks on a clean run, flags breaks.
module count_monitor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       state
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q;
  logic [RUN_W-1:0] run_q;
  logic [WIDTH-1:0] expected_q;
  logic             locked_q;
  logic             error_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic             match_c;
  logic             err_evt_c;

  // expected_q always holds prev+1, so a match is a direct compare against it.
  always_comb begin
    match_c     = (cnt_in == expected_q);
    err_evt_c   = enable && (state_q == ST_LOCKED) && !match_c;
    err_count_d = err_count_q;
    if (err_evt_c) begin
      if (err_clr) begin
        err_count_d = ERR_W'(1);
      end else if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end else if (err_clr) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      expected_q  <= WIDTH'(1);
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      error_q     <= err_evt_c;
      err_count_q <= err_count_d;
      if (enable) begin
        expected_q <= cnt_in + WIDTH'(1);
        case (state_q)
          ST_SYNC: begin
            if (match_c) begin
              run_q <= run_q + RUN_W'(1);
              if (run_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              run_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (!match_c) begin
              run_q    <= '0;
              state_q  <= ST_SYNC;
              locked_q <= 1'b0;
            end
          end
          // IDLE and the unused encoding both take the first sample and sync.
          default: begin
            run_q    <= '0;
            state_q  <= ST_SYNC;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;
  assign state     = state_q;

endmodule
